// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display capture block.
// Holds the active-low segment patterns (bit6=a .. bit0=g), the blank pattern and the
// capture FSM state type. No ports.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLED
    } state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bus between a multiplexed seven-segment driver and the capture block.
//   an, segments         : display lines (active-low), driven by the master side
//   out_digits, out_dash : recovered frame, out_valid pulses on update
//   out_err              : frame contained an unknown pattern (only with SEVEN_SEG_CAPTURE_ERR_EN)
// Modports: master = display side / consumer, slave = capture block.
interface seven_seg_capture_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              segments;
    logic [4*NUM_DIGITS-1:0] out_digits;
    logic [NUM_DIGITS-1:0]   out_dash;
    logic                    out_valid;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
    logic                    out_err;
`endif

    modport master (
        output an, segments,
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        input  out_err,
`endif
        input  out_digits, out_dash, out_valid
    );

    modport slave (
        input  an, segments,
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        output out_err,
`endif
        output out_digits, out_dash, out_valid
    );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment pattern decoder.
//   segments : active-low pattern (bit6=a .. bit0=g)
//   code     : recovered hex code (0 for unknown patterns)
//   dash     : pattern was the dash (code reads F)
//   known    : pattern is in the table
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] code,
    output logic       dash,
    output logic       known
);
    always_comb begin
        code  = 4'h0;
        dash  = 1'b0;
        known = 1'b1;
        case (segments)
            SEG_0:    code = 4'h0;
            SEG_1:    code = 4'h1;
            SEG_2:    code = 4'h2;
            SEG_3:    code = 4'h3;
            SEG_4:    code = 4'h4;
            SEG_5:    code = 4'h5;
            SEG_6:    code = 4'h6;
            SEG_7:    code = 4'h7;
            SEG_8:    code = 4'h8;
            SEG_9:    code = 4'h9;
            SEG_A:    code = 4'hA;
            SEG_B:    code = 4'hB;
            SEG_C:    code = 4'hC;
            SEG_D:    code = 4'hD;
            SEG_DASH: begin
                code = 4'hF;
                dash = 1'b1;
            end
            default:  known = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the digits shown on a multiplexed seven-segment display.
// Each digit is sampled once its enable and pattern have been stable long enough; when every
// digit position has been captured the frame is published with a one-cycle out_valid pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seven_seg_capture_if slave (an/segments in, out_* out)
// Optional: define SEVEN_SEG_CAPTURE_ERR_EN to capture unknown patterns as code 0 and flag
// the frame on out_err; otherwise unknown patterns are skipped.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_capture_if.slave  bus
);
    localparam int unsigned           IdxW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            StableMax  = 8'(STABLE_CYCLES);
    localparam logic [7:0]            StableLast = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] OneLsb     = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0]   an_q, an_prev_q;
    logic [6:0]              seg_q, seg_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   captured_q, captured_d;
    logic [4*NUM_DIGITS-1:0] slot_code_q, slot_code_d;
    logic [NUM_DIGITS-1:0]   slot_dash_q, slot_dash_d;
    logic [4*NUM_DIGITS-1:0] out_digits_q, out_digits_d;
    logic [NUM_DIGITS-1:0]   out_dash_q, out_dash_d;
    logic                    out_valid_q, out_valid_d;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
    logic                    err_acc_q, err_acc_d;
    logic                    out_err_q, out_err_d;
`endif

    logic                  changed, an_ok, capture, capture_ok, frame_done;
    logic [NUM_DIGITS-1:0] sel;
    logic [IdxW-1:0]       idx;
    logic [3:0]            dec_code;
    logic                  dec_dash, dec_known;

    seven_seg_decode u_decode (
        .segments (seg_q),
        .code     (dec_code),
        .dash     (dec_dash),
        .known    (dec_known)
    );

    always_comb begin
        changed = (an_q != an_prev_q) || (seg_q != seg_prev_q);
        sel     = ~an_q;
        an_ok   = (sel != '0) && ((sel & (sel - OneLsb)) == '0);
        idx     = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (sel[i]) idx = IdxW'(i);
        end
    end

    // Stability counter; held at 0 while the enables are not a single active digit.
    always_comb begin
        cnt_d = cnt_q;
        if (changed || !an_ok) begin
            cnt_d = '0;
        end else if (cnt_q < StableMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (changed) state_d = SETTLE;
            SETTLE: begin
                if (!an_ok) begin
                    state_d = IDLE;
                end else if (!changed && cnt_q == StableLast) begin
                    state_d = SAMPLED;
                    capture = 1'b1;
                end
            end
            SAMPLED: if (changed) state_d = SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        capture_ok = capture;
`else
        capture_ok = capture && dec_known;
`endif
        frame_done   = &captured_q;
        slot_code_d  = slot_code_q;
        slot_dash_d  = slot_dash_q;
        // A capture in the completing cycle belongs to the next frame, so clear before set.
        captured_d   = frame_done ? '0 : captured_q;
        if (capture_ok) begin
            captured_d[idx]               = 1'b1;
            slot_code_d[{idx, 2'b00} +: 4] = dec_code;
            slot_dash_d[idx]              = dec_dash;
        end
        out_valid_d  = frame_done;
        out_digits_d = frame_done ? slot_code_q : out_digits_q;
        out_dash_d   = frame_done ? slot_dash_q : out_dash_q;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        err_acc_d    = frame_done ? 1'b0 : err_acc_q;
        if (capture && !dec_known) err_acc_d = 1'b1;
        out_err_d    = frame_done ? err_acc_q : out_err_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q         <= '1;
            an_prev_q    <= '1;
            seg_q        <= SEG_BLANK;
            seg_prev_q   <= SEG_BLANK;
            cnt_q        <= '0;
            state_q      <= IDLE;
            captured_q   <= '0;
            slot_code_q  <= '0;
            slot_dash_q  <= '0;
            out_digits_q <= '0;
            out_dash_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
            err_acc_q    <= 1'b0;
            out_err_q    <= 1'b0;
`endif
        end else begin
            an_q         <= bus.an;
            an_prev_q    <= an_q;
            seg_q        <= bus.segments;
            seg_prev_q   <= seg_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            captured_q   <= captured_d;
            slot_code_q  <= slot_code_d;
            slot_dash_q  <= slot_dash_d;
            out_digits_q <= out_digits_d;
            out_dash_q   <= out_dash_d;
            out_valid_q  <= out_valid_d;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
            err_acc_q    <= err_acc_d;
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign bus.out_digits = out_digits_q;
    assign bus.out_dash   = out_dash_q;
    assign bus.out_valid  = out_valid_q;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
    assign bus.out_err    = out_err_q;
`endif
endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (NUM_DIGITS=4, STABLE_CYCLES=8).
// Works with or without SEVEN_SEG_CAPTURE_ERR_EN defined.
module tb_seven_seg_capture;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   base;

    always #5 clk = ~clk;

    seven_seg_capture_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pulse counter, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.out_valid === 1'b1) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] code);
        case (code)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Drive one digit position with a pattern, then wait n falling edges.
    task automatic show(input int digit, input logic [6:0] seg, input int n);
        logic [3:0] hot;
        hot = 4'b0001 << digit;
        bus.an = ~hot;
        bus.segments = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic show_raw(input logic [3:0] an, input int n);
        bus.an = an;
        bus.segments = 7'b0000000;
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] frames [3];

    initial begin
        rst = 1'b1;
        bus.an = 4'hF;
        bus.segments = 7'b1111111;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_digits", 32'(bus.out_digits), 32'h0);
        chk("reset_dash", 32'(bus.out_dash), 32'h0);
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        chk("reset_err", 32'(bus.out_err), 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Basic scan 1,2,3,4 with exact latency on the last digit.
        show(3, seg_of(4'h1), 20);
        show(2, seg_of(4'h2), 20);
        show(1, seg_of(4'h3), 20);
        show(0, seg_of(4'h4), 10);
        chk("scan_no_early_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        chk("scan_valid_latency", 32'(bus.out_valid), 32'h1);
        chk("scan_digits", 32'(bus.out_digits), 32'h1234);
        chk("scan_dash", 32'(bus.out_dash), 32'h0);
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        chk("scan_err", 32'(bus.out_err), 32'h0);
`endif
        @(negedge clk);
        chk("scan_valid_one_cycle", 32'(bus.out_valid), 32'h0);
        repeat (8) @(negedge clk);
        chk("scan_pulse_count", 32'(pulses), 32'h1);

        // Illegal enables: two lows, then none.
        base = pulses;
        show_raw(4'b0011, 30);
        show_raw(4'b1111, 30);
        chk("bad_an_no_pulse", 32'(pulses), 32'(base));
        chk("bad_an_valid_low", 32'(bus.out_valid), 32'h0);
        chk("bad_an_digits_hold", 32'(bus.out_digits), 32'h1234);

        // Short hold on digit 0 must not capture.
        base = pulses;
        show(3, seg_of(4'h5), 20);
        show(2, seg_of(4'h6), 20);
        show(1, seg_of(4'h7), 20);
        show(0, seg_of(4'h8), 5);
        show_raw(4'b1111, 10);
        chk("short_hold_no_pulse", 32'(pulses), 32'(base));
        show(0, seg_of(4'h9), 20);
        chk("short_hold_pulse", 32'(pulses), 32'(base + 1));
        chk("short_hold_digits", 32'(bus.out_digits), 32'h5679);

        // Dash on digit 2, blank on digit 1.
        base = pulses;
        show(3, seg_of(4'hA), 20);
        show(2, 7'b1111110, 20);
        show(1, 7'b1111111, 20);
        show(0, seg_of(4'hC), 20);
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        chk("blank_err_pulse", 32'(pulses), 32'(base + 1));
        chk("blank_err_digits", 32'(bus.out_digits), 32'hAF0C);
        chk("blank_err_dash", 32'(bus.out_dash), 32'h4);
        chk("blank_err_flag", 32'(bus.out_err), 32'h1);
        show(1, seg_of(4'h0), 20);
        chk("blank_err_partial", 32'(pulses), 32'(base + 1));
`else
        chk("blank_no_frame", 32'(pulses), 32'(base));
        show(1, seg_of(4'h0), 20);
        chk("blank_fill_pulse", 32'(pulses), 32'(base + 1));
        chk("blank_fill_digits", 32'(bus.out_digits), 32'hAF0C);
        chk("blank_fill_dash", 32'(bus.out_dash), 32'h4);
`endif

        // Reset after three captures.
        show(3, seg_of(4'h7), 20);
        show(2, seg_of(4'h8), 20);
        show(1, seg_of(4'h9), 20);
        show(0, seg_of(4'h1), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_digits", 32'(bus.out_digits), 32'h0);
        chk("midrst_dash", 32'(bus.out_dash), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        base = pulses;
        show(0, seg_of(4'hB), 20);
        chk("postrst_partial", 32'(pulses), 32'(base));
        show(3, seg_of(4'h6), 20);
        show(2, seg_of(4'h5), 20);
        show(1, seg_of(4'h4), 20);
        chk("postrst_pulse", 32'(pulses), 32'(base + 1));
        chk("postrst_digits", 32'(bus.out_digits), 32'h654B);

        // Continuous back-to-back frames.
        frames[0] = 16'h89AB;
        frames[1] = 16'hCD01;
        frames[2] = 16'h2345;
        base = pulses;
        for (int f = 0; f < 3; f++) begin
            for (int d = 3; d >= 0; d--) begin
                show(d, seg_of(frames[f][4*d +: 4]), 20);
            end
            chk("b2b_pulse", 32'(pulses), 32'(base + f + 1));
            chk("b2b_digits", 32'(bus.out_digits), 32'(frames[f]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digit positions, legal range 1..8.
REQ-002 SHALL have parameter STABLE_CYCLES, default 8: number of consecutive unchanged cycles needed before a sample, legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 an  input  NUM_DIGITS  digit enables, active-low, expected one-hot-low; bit i selects digit i.
REQ-006 segments  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-007 out_digits  output  4*NUM_DIGITS  recovered codes; digit i occupies bits [4i+3:4i].
REQ-008 out_dash  output  NUM_DIGITS  bit i high when digit i showed the dash pattern.
REQ-009 out_valid  output  1  one-cycle pulse when out_digits, out_dash and out_err update.
REQ-010 out_err  output  1  frame contained an unrecognised pattern; present only under the ERR macro.

Function
REQ-011 SHALL decode patterns as follows: 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 1111110→code F with dash=1.
REQ-012 SHALL treat any other pattern, including blank 1111111, as unrecognised.
REQ-013 SHALL register an and segments once on input, so all decisions use the registered values.
REQ-014 SHALL run a stability counter: reset to 0 when {an,segments} differs from the previous cycle, otherwise increment, saturating at STABLE_CYCLES.
REQ-015 SHALL use the states IDLE, SETTLE, SAMPLED, with these transitions:
- IDLE→SETTLE on any input change.
- SETTLE→SAMPLED in the cycle the counter reaches STABLE_CYCLES-1 with an one-hot-low.
- SAMPLED→SETTLE on the next input change.
- SETTLE→IDLE when an is not one-hot-low.
REQ-016 On entry to SAMPLED, SHALL write the decoded code and dash flag into slot i and set captured[i]; a digit is sampled at most once per stable period.
REQ-017 If slot i is rewritten before the frame completes, SHALL keep the latest value.
REQ-018 SHALL ignore an values that are all-high or have multiple bits low: no capture, counter held at 0.
REQ-019 When all captured bits are set, SHALL on the next cycle pulse out_valid for 1 cycle, copy the slots to out_digits/out_dash, and clear captured and the error accumulator.
REQ-020 Latency: out_valid SHALL assert exactly 1 cycle after the capture cycle of the last slot; outputs hold their values between pulses.
REQ-021 If the frame completes and a new capture happens in the same cycle, SHALL let the new capture start the next frame; it is not lost.

Reset
REQ-022 rst SHALL force IDLE, counter=0, captured=0, out_digits=0, out_dash=0, out_valid=0 and out_err=0 immediately, independent of clk.
REQ-023 Reset mid-frame SHALL discard partial captures; the first frame after reset needs all NUM_DIGITS slots freshly captured.

Configuration
REQ-024 Macro SEVEN_SEG_CAPTURE_ERR_EN SHALL control error reporting:
- Defined: an unrecognised pattern captures code 0 in its slot and sets the frame error accumulator, reported on out_err with out_valid.
- Undefined: unrecognised patterns are skipped (no capture, captured bit unchanged), out_err is absent, and no error logic is built.

Structure
REQ-025 Package seven_seg_pkg SHALL hold:
- the 15 segment pattern constants
- SEG_BLANK = 1111111
- the state enumeration type
REQ-026 Sub-module seven_seg_decode (combinational: pattern→code, dash, known) SHALL implement the REQ-011 table, instantiated once.

Verification
REQ-027 NUM_DIGITS=4, STABLE_CYCLES=8; scan digits 3..0 showing 1,2,3,4 for 20 cycles each → out_valid pulse with out_digits=16'h1234, out_dash=0.
REQ-028 Digit 0 held for only 5 cycles, then valid scan → no capture from the short hold; out_valid only after a full 8-cycle stable hold.
REQ-029 an=4'b0011 or 4'b1111 for 30 cycles → no capture, out_valid stays 0.
REQ-030 Digit 2 shows 1111110 → out_dash[2]=1 with nibble 2 = F; digit 1 shows 1111111 → out_err=1 (macro defined) or no frame completion (undefined).
REQ-031 Assert rst after 3 of 4 digits captured → outputs 0 immediately; the next frame needs all 4 digits.
REQ-032 Back-to-back frames with continuous scanning → one out_valid pulse per full scan, no dropped frames.
